wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter DATA_W, default 32, register and datapath width.
REQ-002 Parameter ADDR_W, default 5, register index width; register count is 2**ADDR_W.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 wb_mem_to_reg  input  1  select load data (1) or ALU result (0) for writeback.
REQ-006 wb_reg_write  input  1  writeback enable from the MEM/WB register.
REQ-007 wb_read_data  input  DATA_W  load data from the MEM/WB register.
REQ-008 wb_address  input  DATA_W  ALU result from the MEM/WB register.
REQ-009 wb_reg_dest  input  ADDR_W  destination register index.
REQ-010 rs_addr  input  ADDR_W  read port A index (ID stage).
REQ-011 rt_addr  input  ADDR_W  read port B index (ID stage).
REQ-012 rs_data  output  DATA_W  read port A data, combinational.
REQ-013 rt_data  output  DATA_W  read port B data, combinational.
REQ-014 wb_data  output  DATA_W  selected writeback value, combinational, for the forwarding network.
REQ-015 wb_count  output  32  number of committed register writes since reset.

Function
REQ-016 wb_data SHALL equal wb_read_data when wb_mem_to_reg=1, else wb_address, independent of wb_reg_write.
REQ-017 A commit SHALL occur on a rising clk edge when wb_reg_write=1, wb_reg_dest!=0, and rst=0.
REQ-018 On a commit, register[wb_reg_dest] SHALL take wb_data; no other register changes.
REQ-019 Register 0 SHALL always read 0; writes to index 0 SHALL be discarded and not counted.
REQ-020 Each read port SHALL return register[addr] with zero added latency.
REQ-021 Write-through bypass: when wb_reg_write=1, wb_reg_dest!=0, and wb_reg_dest equals a read address, that port SHALL return wb_data in the same cycle.
REQ-022 Both read ports SHALL bypass independently; if rs_addr==rt_addr, both SHALL return identical data.
REQ-023 wb_count SHALL increment by 1 on every commit and wrap from 0xFFFFFFFF to 0 without flagging.
REQ-024 Writes with wb_reg_write=0 SHALL change no state, regardless of the other wb_* inputs.
REQ-025 While rst=1, rs_data and rt_data SHALL read 0, and the bypass SHALL be disabled.

Reset
REQ-026 Asserting rst SHALL immediately clear all registers and wb_count to 0, without waiting for clk.
REQ-027 A commit coincident with a rising rst edge SHALL be lost; the register SHALL read 0 after reset.
REQ-028 After rst deasserts, the first commit SHALL occur on the first rising clk edge that meets REQ-017.

Structure
REQ-029 DATA_W, ADDR_W, and the constant REG_ZERO (index 0) SHALL live in the shared pipeline package, which other pipeline blocks also use.
REQ-030 Storage SHALL be a single flop array with one write port and two combinational read ports; no sub-module is required.
REQ-031 The writeback mux SHALL be inline and shared by the write path, the bypass, and wb_data.

Verification
REQ-032 Reset: assert rst mid-run, then read all 32 indices on both ports -> all 0, wb_count=0.
REQ-033 Write and read back: commit wb_reg_dest=5, wb_mem_to_reg=0, wb_address=0x1234 -> next cycle rs_addr=5 reads 0x1234, wb_count=1.
REQ-034 Bypass: in one cycle, commit wb_reg_dest=9, wb_mem_to_reg=1, wb_read_data=0xDEADBEEF, with rs_addr=rt_addr=9 -> both ports read 0xDEADBEEF in that cycle.
REQ-035 Register 0: commit wb_reg_dest=0, wb_address=0xFFFF -> rs_addr=0 reads 0, wb_count unchanged.
REQ-036 Disabled write: wb_reg_write=0, wb_reg_dest=3, wb_address=0x55 -> register 3 keeps its prior value, and wb_data still shows 0x55.
REQ-037 Wrap: force wb_count to 0xFFFFFFFF via back-door, then perform 1 commit -> wb_count=0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared pipeline widths and register-index constants
package wb_regfile_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int REG_ZERO = 0;
endpackage

// File: rtl/wb_regfile.sv
// wb_regfile: writeback-stage register file with write-through bypass and commit counter
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = wb_regfile_pkg::DATA_W,
    parameter int ADDR_W = wb_regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_mem_to_reg,
    input  logic              wb_reg_write,
    input  logic [DATA_W-1:0] wb_read_data,
    input  logic [DATA_W-1:0] wb_address,
    input  logic [ADDR_W-1:0] wb_reg_dest,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic [31:0]       wb_count
);
    localparam int N = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);
    logic [DATA_W-1:0] regs [N];
    logic [31:0] count_q;
    logic commit;
    // Index 0 is never written, so regs[0] stays at its reset value of 0.
    always_comb begin
        wb_data = wb_mem_to_reg ? wb_read_data : wb_address;
        commit = wb_reg_write && wb_reg_dest != ZERO;
        rs_data = rst ? '0 : (commit && wb_reg_dest == rs_addr) ? wb_data : regs[rs_addr];
        rt_data = rst ? '0 : (commit && wb_reg_dest == rt_addr) ? wb_data : regs[rt_addr];
        wb_count = count_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) regs[i] <= '0;
            count_q <= '0;
        end else if (commit) begin
            regs[wb_reg_dest] <= wb_data;
            count_q <= count_q + 32'd1;
        end
    end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed and random scoreboard bench for wb_regfile
module tb_wb_regfile;
    logic clk = 1'b0, rst = 1'b1, wb_mem_to_reg = 1'b0, wb_reg_write = 1'b0;
    logic [31:0] wb_read_data = '0, wb_address = '0;
    logic [4:0] wb_reg_dest = '0, rs_addr = '0, rt_addr = '0;
    logic [31:0] rs_data, rt_data, wb_data, wb_count;
    typedef struct {
        string tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];
    logic [31:0] model [32];
    logic [31:0] cnt = '0;
    int n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .rst(rst), .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
        .wb_read_data(wb_read_data), .wb_address(wb_address), .wb_reg_dest(wb_reg_dest),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .wb_data(wb_data), .wb_count(wb_count)
    );

    task automatic expect_val(input string tag, input logic [31:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        e = sb.pop_front();
        n_checks++;
        assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
        end
    endtask

    function automatic logic [31:0] sel();
        return wb_mem_to_reg ? wb_read_data : wb_address;
    endfunction

    function automatic logic [31:0] rd(input logic [4:0] a);
        if (rst) return '0;
        if (wb_reg_write && wb_reg_dest != 5'd0 && wb_reg_dest == a) return sel();
        return model[a];
    endfunction

    task automatic drive(input logic we, input logic mtr, input logic [31:0] rdata,
                         input logic [31:0] addr, input logic [4:0] dest,
                         input logic [4:0] rs, input logic [4:0] rt);
        wb_reg_write = we;
        wb_mem_to_reg = mtr;
        wb_read_data = rdata;
        wb_address = addr;
        wb_reg_dest = dest;
        rs_addr = rs;
        rt_addr = rt;
    endtask

    task automatic cyc(input string tag);
        #1;
        expect_val({tag, "_rs"}, rd(rs_addr));
        expect_val({tag, "_rt"}, rd(rt_addr));
        expect_val({tag, "_wbdata"}, sel());
        check(rs_data);
        check(rt_data);
        check(wb_data);
        @(posedge clk);
        if (!rst && wb_reg_write && wb_reg_dest != 5'd0) begin
            model[wb_reg_dest] = sel();
            cnt++;
        end
        #1;
        expect_val({tag, "_count"}, cnt);
        check(wb_count);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;
        @(negedge clk);
        drive(1, 0, 0, 32'h0BAD, 7, 7, 7);
        cyc("in_reset");
        rst = 1'b0;
        for (int i = 1; i < 32; i++) begin
            drive(1, i[0], $urandom, $urandom, 5'(i), 5'(i), 5'(31 - i));
            cyc("fill");
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = '0;
        cnt = '0;
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i);
            rt_addr = 5'(i);
            #1;
            expect_val("rst_rs", 32'h0);
            expect_val("rst_rt", 32'h0);
            check(rs_data);
            check(rt_data);
        end
        expect_val("rst_count", 32'h0);
        check(wb_count);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 32'h9999, 32'h1234, 5, 0, 0);
        cyc("w5");
        drive(0, 0, 0, 0, 0, 5, 0);
        #1;
        expect_val("rb5_lit", 32'h1234);
        expect_val("rb5_count_lit", 32'h1);
        check(rs_data);
        check(wb_count);
        cyc("rb5");
        drive(1, 1, 32'hDEADBEEF, 32'h1111, 9, 9, 9);
        #1;
        expect_val("byp9_rs_lit", 32'hDEADBEEF);
        expect_val("byp9_rt_lit", 32'hDEADBEEF);
        check(rs_data);
        check(rt_data);
        cyc("byp9");
        drive(1, 0, 0, 32'hFFFF, 0, 0, 0);
        cyc("w0");
        drive(0, 0, 0, 0, 0, 0, 9);
        cyc("rb0");
        drive(1, 0, 0, 32'hA5A5, 3, 0, 0);
        cyc("w3");
        drive(0, 0, 0, 32'h55, 3, 3, 3);
        #1;
        expect_val("nowr_wbdata_lit", 32'h55);
        expect_val("nowr_rt_lit", 32'hA5A5);
        check(wb_data);
        check(rt_data);
        cyc("nowr");
        drive(0, 0, 0, 0, 0, 3, 0);
        cyc("rb3");
        drive(1, 0, 0, 32'h777, 5, 9, 5);
        cyc("byp_rt_only");
        drive(1, 1, 32'h4242, 0, 9, 5, 9);
        cyc("byp_rs_only");
        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            cyc("rand");
        end
        drive(1, 0, 0, 32'hCAFE, 12, 12, 12);
        @(posedge clk);
        rst = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = '0;
        cnt = '0;
        #1;
        expect_val("rst_edge_count", 32'h0);
        check(wb_count);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 12, 12);
        #1;
        expect_val("rst_edge_rs", 32'h0);
        check(rs_data);
        cyc("rst_edge");
        dut.count_q = 32'hFFFF_FFFF;
        cnt = 32'hFFFF_FFFF;
        drive(1, 0, 0, 32'h1, 4, 4, 0);
        cyc("wrap");
        drive(0, 0, 0, 0, 0, 4, 0);
        #1;
        expect_val("wrap_count_lit", 32'h0);
        check(wb_count);
        cyc("after_wrap");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
